hilo_muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the HI/LO register pair and the multiply/divide resource of the MIPS core. It replaces the single-cycle HI/LO update path. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO issues from the decode stage and runs 32-iteration shift-add or restoring-divide sequences. It raises `stall` to the core whenever an issue or an MFHI/MFLO read conflicts with an operation in flight.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 42 ++++
 rtl/hilo_muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: issue opcodes, FSM states and
// the kind of sign fix-up pending in the FIX cycle.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FIX_MUL = 2'd0,
        FIX_DIV = 2'd1,
        FIX_DZ  = 2'd2
    } fix_t;

    localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: radix-2 shift-add multiply (LSB first) or
// restoring divide (MSB first), purely combinational.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        div_mode,
    input  logic [63:0] acc,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [4:0]  count,
    output logic [63:0] acc_next,
    output logic        q_bit
);

    logic        mul_bit;
    logic [32:0] mul_sum;
    logic [32:0] trial;
    logic [32:0] diff;
    logic [4:0]  bit_idx;

    // Multiply: acc = {partial high, low product bits}; add into the top half, shift right.
    always_comb begin
        bit_idx = ITER_LAST - count;
        mul_bit = opb[bit_idx];
        mul_sum = {1'b0, acc[63:32]} + (mul_bit ? {1'b0, opa} : 33'd0);
        trial   = {acc[63:32], acc[31]};
        diff    = trial - {1'b0, opb};
        q_bit   = 1'b0;
        if (div_mode) begin
            // Divide: acc = {remainder, dividend/quotient}; the quotient bit enters at bit 0.
            q_bit = ~diff[32];
            if (q_bit) begin
                acc_next = {diff[31:0], acc[30:0], 1'b0};
            end else begin
                acc_next = {trial[31:0], acc[30:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc[31:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair with a multi-cycle multiply/divide sequencer; stalls the core
// on any issue or MFHI/MFLO read while an operation is in flight.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clock_enable,
    input  logic        start,
    input  op_t         op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        read_req,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    state_t      state;
    state_t      state_next;
    fix_t        fix_kind;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        neg;
    logic        rneg;

    logic        is_signed;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] step_acc;
    logic        step_q;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    // |x| as 32-bit unsigned: 0x80000000 negates to itself, which reads as 2^31.
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        sign_a    = is_signed & rs_val[31];
        sign_b    = is_signed & rt_val[31];
        mag_a     = sign_a ? neg32(rs_val) : rs_val;
        mag_b     = sign_b ? neg32(rt_val) : rt_val;
    end

    muldiv_step u_step (
        .div_mode (state == DIV),
        .acc      (acc),
        .opa      (opa),
        .opb      (opb),
        .count    (count),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: state_next = MUL;
                        OP_DIV, OP_DIVU:   state_next = (rt_val == 32'd0) ? FIX : DIV;
                        default:           state_next = IDLE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (count == 5'd0) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (clock_enable) begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 5'd0;
            acc      <= 64'd0;
            opa      <= 32'd0;
            opb      <= 32'd0;
            neg      <= 1'b0;
            rneg     <= 1'b0;
            fix_kind <= FIX_MUL;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (clock_enable) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                opa      <= mag_a;
                                opb      <= mag_b;
                                neg      <= sign_a ^ sign_b;
                                acc      <= 64'd0;
                                count    <= ITER_LAST;
                                fix_kind <= FIX_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (rt_val == 32'd0) begin
                                    // Raw dividend is what lands in HI on a divide by zero.
                                    opa      <= rs_val;
                                    fix_kind <= FIX_DZ;
                                end else begin
                                    opb      <= mag_b;
                                    acc      <= {32'd0, mag_a};
                                    neg      <= sign_a ^ sign_b;
                                    rneg     <= sign_a;
                                    count    <= ITER_LAST;
                                    fix_kind <= FIX_DIV;
                                end
                            end
                            OP_MTHI: hi <= rs_val;
                            OP_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    acc   <= step_acc | {63'd0, step_q};
                    count <= count - 5'd1;
                end
                FIX: begin
                    case (fix_kind)
                        FIX_MUL: {hi, lo} <= neg ? neg64(acc) : acc;
                        FIX_DIV: begin
                            lo <= neg  ? neg32(acc[31:0])  : acc[31:0];
                            hi <= rneg ? neg32(acc[63:32]) : acc[63:32];
                        end
                        FIX_DZ: begin
                            hi <= opa;
                            lo <= 32'hFFFF_FFFF;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign stall       = (start || read_req) && busy;
    assign div_by_zero = (state == FIX) && (fix_kind == FIX_DZ);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed and randomized checks of the HI/LO multiply/divide sequencer against a
// plain-arithmetic reference model.
module tb_hilo_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clock_enable;
    logic        start;
    op_t         op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        read_req;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    hilo_muldiv_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .clock_enable (clock_enable),
        .start        (start),
        .op           (op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .read_req     (read_req),
        .busy         (busy),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo),
        .div_by_zero  (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: architectural result and timing of one issue, from ISA arithmetic.
    task automatic model(input op_t o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output int elen, output int edz);
        logic signed [63:0] sp;
        logic [63:0] up;
        int sa;
        int sb;
        sa = a;
        sb = b;
        eh = mhi;
        el = mlo;
        elen = 33;
        edz = 0;
        case (o)
            OP_MULT: begin
                sp = 64'(sa) * 64'(sb);
                {eh, el} = sp;
            end
            OP_MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                {eh, el} = up;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF; elen = 1; edz = 1;
                end else if (o == OP_DIVU) begin
                    el = a / b; eh = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 32'd0;
                end else begin
                    el = sa / sb; eh = sa % sb;
                end
            end
            OP_MTHI: begin eh = a; elen = 0; end
            OP_MTLO: begin el = a; elen = 0; end
            default: elen = 0;
        endcase
    endtask

    task automatic do_op(input string tag, input op_t o, input logic [31:0] a,
                         input logic [31:0] b, input int gap, input bit hold);
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] oh;
        logic [31:0] ol;
        int elen;
        int edz;
        int cyc;
        int dzc;
        model(o, a, b, eh, el, elen, edz);
        oh = mhi;
        ol = mlo;
        op = o; rs_val = a; rt_val = b; start = 1'b1; read_req = 1'b1;
        #1;
        chk({tag, "_accept_stall"}, 64'(stall), 64'd0);
        tick();
        if (hold) begin
            op = OP_MTHI; rs_val = 32'hDEAD_BEEF; start = 1'b1; read_req = 1'b1;
        end else begin
            op = OP_NONE; start = 1'b0; read_req = 1'b0;
        end
        #1;
        cyc = 0;
        dzc = 0;
        while (busy && cyc < 200) begin
            if (div_by_zero) dzc++;
            if (hold) chk({tag, "_stall_busy"}, 64'(stall), 64'd1);
            if (cyc == 5) chk({tag, "_hilo_frozen"}, {hi, lo}, {oh, ol});
            if (gap > 0 && cyc == 10) clock_enable = 1'b0;
            if (gap > 0 && cyc == 10 + gap) clock_enable = 1'b1;
            cyc++;
            tick();
        end
        start = 1'b0;
        op = OP_NONE;
        #1;
        if (hold) chk({tag, "_stall_drop"}, 64'(stall), 64'd0);
        read_req = 1'b0;
        chk({tag, "_busy_len"}, 64'(cyc), 64'(elen + gap));
        chk({tag, "_dz_pulses"}, 64'(dzc), 64'(edz));
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        mhi = eh;
        mlo = el;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        op_t ro;
        reset = 1'b1; clock_enable = 1'b1; start = 1'b0; op = OP_NONE;
        rs_val = 32'd0; rt_val = 32'd0; read_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_dz", 64'(div_by_zero), 64'd0);

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
        do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 0, 1'b0);
        do_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
        do_op("stall_hold", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b1);
        do_op("ce_gap", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0);
        do_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'd0, 0, 1'b0);

        // Abort a multiply after ten iterations.
        op = OP_MULT; rs_val = 32'd12345; rt_val = 32'd678; start = 1'b1;
        tick();
        start = 1'b0; op = OP_NONE;
        repeat (10) tick();
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        mhi = 32'd0;
        mlo = 32'd0;
        do_op("mthi_after_reset", OP_MTHI, 32'h0000_1234, 32'd0, 0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            ro = op_t'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            do_op($sformatf("rand%0d", i), ro, ra, rb, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
